// File: rtl/etapa_ex.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU and the
// EX/MEM pipeline register (hold on i_enable=0, bubble on i_flush).
module etapa_ex (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_flush,
    input  logic [31:0] i_rs_data,
    input  logic [31:0] i_rt_data,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic [2:0]  i_ALU_op,
    input  logic        i_ALU_src,
    input  logic        i_reg_dst,
    input  logic        i_link,
    input  logic [31:0] i_return_addr,
    input  logic        i_WB_write,
    input  logic        i_WB_mem_to_reg,
    input  logic        i_MEM_read,
    input  logic        i_MEM_write,
    input  logic        i_MEM_unsigned,
    input  logic [1:0]  i_MEM_byte_half_word,
    input  logic        i_fwd_WB_write,
    input  logic [4:0]  i_fwd_WB_reg,
    input  logic [31:0] i_fwd_WB_data,
    output logic [31:0] o_ALU_result,
    output logic [31:0] o_data_to_write_in_MEM,
    output logic [4:0]  o_write_reg,
    output logic        o_WB_write,
    output logic        o_WB_mem_to_reg,
    output logic        o_MEM_read,
    output logic        o_MEM_write,
    output logic        o_MEM_unsigned,
    output logic [1:0]  o_MEM_byte_half_word
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam logic [REG_W-1:0] LINK_REG = REG_W'(31);

    logic [DATA_W-1:0] r_ALU_result;
    logic [DATA_W-1:0] r_data_to_write_in_MEM;
    logic [REG_W-1:0]  r_write_reg;
    logic              r_WB_write;
    logic              r_WB_mem_to_reg;
    logic              r_MEM_read;
    logic              r_MEM_write;
    logic              r_MEM_unsigned;
    logic [1:0]        r_MEM_byte_half_word;

    logic              w_exmem_fwd_ok;
    logic              w_memwb_fwd_ok;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_rt_fwd;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_imm_zext;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_result;
    logic [REG_W-1:0]  w_dest;

    // Loads in EX/MEM are never forwarded; the hazard unit stalls those.
    assign w_exmem_fwd_ok = r_WB_write && !r_MEM_read && (r_write_reg != '0);
    assign w_memwb_fwd_ok = i_fwd_WB_write && (i_fwd_WB_reg != '0);

    always_comb begin
        w_op_a = i_rs_data;
        if (w_exmem_fwd_ok && (r_write_reg == i_rs))
            w_op_a = r_ALU_result;
        else if (w_memwb_fwd_ok && (i_fwd_WB_reg == i_rs))
            w_op_a = i_fwd_WB_data;
    end

    always_comb begin
        w_rt_fwd = i_rt_data;
        if (w_exmem_fwd_ok && (r_write_reg == i_rt))
            w_rt_fwd = r_ALU_result;
        else if (w_memwb_fwd_ok && (i_fwd_WB_reg == i_rt))
            w_rt_fwd = i_fwd_WB_data;
    end

    assign w_op_b     = i_ALU_src ? i_imm : w_rt_fwd;
    assign w_imm_zext = {16'h0000, i_imm[15:0]};

    always_comb begin
        w_alu = '0;
        case (i_ALU_op)
            3'b000: w_alu = w_op_a + w_op_b;
            3'b001: w_alu = w_op_a - w_op_b;
            3'b010: begin
                case (i_funct)
                    6'h00: w_alu = w_op_b << i_shamt;
                    6'h02: w_alu = w_op_b >> i_shamt;
                    6'h03: w_alu = DATA_W'($signed(w_op_b) >>> i_shamt);
                    6'h04: w_alu = w_op_b << w_op_a[4:0];
                    6'h06: w_alu = w_op_b >> w_op_a[4:0];
                    6'h07: w_alu = DATA_W'($signed(w_op_b) >>> w_op_a[4:0]);
                    6'h09: w_alu = i_return_addr;
                    6'h21: w_alu = w_op_a + w_op_b;
                    6'h23: w_alu = w_op_a - w_op_b;
                    6'h24: w_alu = w_op_a & w_op_b;
                    6'h25: w_alu = w_op_a | w_op_b;
                    6'h26: w_alu = w_op_a ^ w_op_b;
                    6'h27: w_alu = ~(w_op_a | w_op_b);
                    6'h2A: w_alu = DATA_W'($signed(w_op_a) < $signed(w_op_b));
                    6'h2B: w_alu = DATA_W'(w_op_a < w_op_b);
                    default: w_alu = '0;
                endcase
            end
            3'b011: w_alu = w_op_a & w_imm_zext;
            3'b100: w_alu = w_op_a | w_imm_zext;
            3'b101: w_alu = w_op_a ^ w_imm_zext;
            3'b110: w_alu = {i_imm[15:0], 16'h0000};
            3'b111: w_alu = DATA_W'($signed(w_op_a) < $signed(w_op_b));
            default: w_alu = '0;
        endcase
    end

    assign w_result = i_link ? i_return_addr : w_alu;
    assign w_dest   = (i_link && !i_reg_dst) ? LINK_REG :
                      (i_reg_dst ? i_rd : i_rt);

    // EX/MEM register: hold beats flush; flush loads an all-zero bubble.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ALU_result           <= '0;
            r_data_to_write_in_MEM <= '0;
            r_write_reg            <= '0;
            r_WB_write             <= 1'b0;
            r_WB_mem_to_reg        <= 1'b0;
            r_MEM_read             <= 1'b0;
            r_MEM_write            <= 1'b0;
            r_MEM_unsigned         <= 1'b0;
            r_MEM_byte_half_word   <= '0;
        end else if (i_enable) begin
            if (i_flush) begin
                r_ALU_result           <= '0;
                r_data_to_write_in_MEM <= '0;
                r_write_reg            <= '0;
                r_WB_write             <= 1'b0;
                r_WB_mem_to_reg        <= 1'b0;
                r_MEM_read             <= 1'b0;
                r_MEM_write            <= 1'b0;
                r_MEM_unsigned         <= 1'b0;
                r_MEM_byte_half_word   <= '0;
            end else begin
                r_ALU_result           <= w_result;
                r_data_to_write_in_MEM <= w_rt_fwd;
                r_write_reg            <= w_dest;
                r_WB_write             <= i_WB_write;
                r_WB_mem_to_reg        <= i_WB_mem_to_reg;
                r_MEM_read             <= i_MEM_read;
                r_MEM_write            <= i_MEM_write;
                r_MEM_unsigned         <= i_MEM_unsigned;
                r_MEM_byte_half_word   <= i_MEM_byte_half_word;
            end
        end
    end

    assign o_ALU_result           = r_ALU_result;
    assign o_data_to_write_in_MEM = r_data_to_write_in_MEM;
    assign o_write_reg            = r_write_reg;
    assign o_WB_write             = r_WB_write;
    assign o_WB_mem_to_reg        = r_WB_mem_to_reg;
    assign o_MEM_read             = r_MEM_read;
    assign o_MEM_write            = r_MEM_write;
    assign o_MEM_unsigned         = r_MEM_unsigned;
    assign o_MEM_byte_half_word   = r_MEM_byte_half_word;

endmodule

// File: tb/tb_etapa_ex.sv
// Bench for etapa_ex: directed pipeline scenarios followed by random
// instructions, all checked against an instruction-level reference model.
module tb_etapa_ex;

    logic        i_clk = 1'b0;
    logic        i_reset, i_enable, i_flush;
    logic [31:0] i_rs_data, i_rt_data, i_imm, i_return_addr, i_fwd_WB_data;
    logic [4:0]  i_rs, i_rt, i_rd, i_shamt, i_fwd_WB_reg;
    logic [5:0]  i_funct;
    logic [2:0]  i_ALU_op;
    logic        i_ALU_src, i_reg_dst, i_link;
    logic        i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned;
    logic [1:0]  i_MEM_byte_half_word;
    logic        i_fwd_WB_write;
    logic [31:0] o_ALU_result, o_data_to_write_in_MEM;
    logic [4:0]  o_write_reg;
    logic        o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write, o_MEM_unsigned;
    logic [1:0]  o_MEM_byte_half_word;

    int errors = 0;
    int checks = 0;

    // Expected EX/MEM contents
    logic [31:0] m_res, m_data;
    logic [4:0]  m_wreg;
    logic        m_wb, m_m2r, m_rd, m_wr, m_uns;
    logic [1:0]  m_bhw;

    etapa_ex dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_flush(i_flush),
        .i_rs_data(i_rs_data), .i_rt_data(i_rt_data), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd),
        .i_imm(i_imm), .i_shamt(i_shamt), .i_funct(i_funct), .i_ALU_op(i_ALU_op),
        .i_ALU_src(i_ALU_src), .i_reg_dst(i_reg_dst), .i_link(i_link),
        .i_return_addr(i_return_addr), .i_WB_write(i_WB_write),
        .i_WB_mem_to_reg(i_WB_mem_to_reg), .i_MEM_read(i_MEM_read),
        .i_MEM_write(i_MEM_write), .i_MEM_unsigned(i_MEM_unsigned),
        .i_MEM_byte_half_word(i_MEM_byte_half_word), .i_fwd_WB_write(i_fwd_WB_write),
        .i_fwd_WB_reg(i_fwd_WB_reg), .i_fwd_WB_data(i_fwd_WB_data),
        .o_ALU_result(o_ALU_result), .o_data_to_write_in_MEM(o_data_to_write_in_MEM),
        .o_write_reg(o_write_reg), .o_WB_write(o_WB_write),
        .o_WB_mem_to_reg(o_WB_mem_to_reg), .o_MEM_read(o_MEM_read),
        .o_MEM_write(o_MEM_write), .o_MEM_unsigned(o_MEM_unsigned),
        .o_MEM_byte_half_word(o_MEM_byte_half_word)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_res = 0; m_data = 0; m_wreg = 0;
        m_wb = 0; m_m2r = 0; m_rd = 0; m_wr = 0; m_uns = 0; m_bhw = 0;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".result"}, o_ALU_result, m_res);
        chk({tag, ".data"},   o_data_to_write_in_MEM, m_data);
        chk({tag, ".wreg"},   32'(o_write_reg), 32'(m_wreg));
        chk({tag, ".ctrl"},   32'({o_WB_write, o_WB_mem_to_reg, o_MEM_read, o_MEM_write,
                                   o_MEM_unsigned, o_MEM_byte_half_word}),
                              32'({m_wb, m_m2r, m_rd, m_wr, m_uns, m_bhw}));
    endtask

    // Value a register read sees, given the newest producers
    function automatic logic [31:0] read_reg(input logic [4:0] idx, input logic [31:0] rf);
        if (m_wb && !m_rd && m_wreg != 0 && m_wreg == idx) return m_res;
        if (i_fwd_WB_write && i_fwd_WB_reg != 0 && i_fwd_WB_reg == idx) return i_fwd_WB_data;
        return rf;
    endfunction

    function automatic logic [31:0] sra_ref(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int k = 0; k < n; k++) r = {r[31], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        longint z  = longint'({48'h0, i_imm[15:0]});
        case (i_ALU_op)
            3'd0: return 32'(ua + ub);
            3'd1: return 32'(ua - ub);
            3'd3: return a & 32'(z);
            3'd4: return a | 32'(z);
            3'd5: return a ^ 32'(z);
            3'd6: return 32'(z * 65536);
            3'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: case (i_funct)
                6'h00: return 32'(ub * (longint'(1) << i_shamt));
                6'h02: return 32'(ub / (longint'(1) << i_shamt));
                6'h03: return sra_ref(b, int'(i_shamt));
                6'h04: return 32'(ub * (longint'(1) << a[4:0]));
                6'h06: return 32'(ub / (longint'(1) << a[4:0]));
                6'h07: return sra_ref(b, int'(a[4:0]));
                6'h09: return i_return_addr;
                6'h21: return 32'(ua + ub);
                6'h23: return 32'(ua - ub);
                6'h24: return a & b;
                6'h25: return a | b;
                6'h26: return a ^ b;
                6'h27: return ~(a | b);
                6'h2A: return (sa < sb) ? 32'd1 : 32'd0;
                6'h2B: return (ua < ub) ? 32'd1 : 32'd0;
                default: return 32'd0;
            endcase
        endcase
    endfunction

    // One clock: predict from current inputs and model state, then compare
    task automatic step(input string tag);
        logic [31:0] a, rtv, b, res;
        logic [4:0]  dst;
        a   = read_reg(i_rs, i_rs_data);
        rtv = read_reg(i_rt, i_rt_data);
        b   = i_ALU_src ? i_imm : rtv;
        res = i_link ? i_return_addr : ref_alu(a, b);
        dst = (i_link && !i_reg_dst) ? 5'd31 : (i_reg_dst ? i_rd : i_rt);
        @(posedge i_clk);
        #1;
        if (i_enable) begin
            if (i_flush) model_clear();
            else begin
                m_res = res; m_data = rtv; m_wreg = dst;
                m_wb = i_WB_write; m_m2r = i_WB_mem_to_reg; m_rd = i_MEM_read;
                m_wr = i_MEM_write; m_uns = i_MEM_unsigned; m_bhw = i_MEM_byte_half_word;
            end
        end
        compare_all(tag);
    endtask

    task automatic clear_inputs();
        i_enable = 1; i_flush = 0;
        i_rs_data = 0; i_rt_data = 0; i_imm = 0; i_return_addr = 0; i_fwd_WB_data = 0;
        i_rs = 0; i_rt = 0; i_rd = 0; i_shamt = 0; i_fwd_WB_reg = 0;
        i_funct = 0; i_ALU_op = 0; i_ALU_src = 0; i_reg_dst = 0; i_link = 0;
        i_WB_write = 0; i_WB_mem_to_reg = 0; i_MEM_read = 0; i_MEM_write = 0;
        i_MEM_unsigned = 0; i_MEM_byte_half_word = 0; i_fwd_WB_write = 0;
    endtask

    task automatic rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
        clear_inputs();
        i_ALU_op = 3'b010; i_funct = fn; i_rs = rs; i_rt = rt; i_rd = rd;
        i_rs_data = rsd; i_rt_data = rtd; i_reg_dst = 1; i_WB_write = 1;
    endtask

    initial begin
        clear_inputs();
        model_clear();
        i_reset = 1;
        repeat (2) @(posedge i_clk);
        #1;
        compare_all("reset");
        i_reset = 0;

        rtype(6'h21, 5'd1, 5'd2, 5'd3, 32'd5, 32'hFFFF_FFFE);
        step("add");
        chk("add.const_result", o_ALU_result, 32'd3);
        chk("add.const_wreg", 32'(o_write_reg), 32'd3);
        chk("add.const_wb", 32'(o_WB_write), 32'd1);

        rtype(6'h21, 5'd1, 5'd0, 5'd4, 32'd7, 32'd0);
        step("addu_r4");
        rtype(6'h23, 5'd4, 5'd4, 5'd5, 32'd0, 32'd0);
        i_fwd_WB_write = 1; i_fwd_WB_reg = 5'd4; i_fwd_WB_data = 32'd9;
        step("subu_fwd");
        chk("subu_fwd.const", o_ALU_result, 32'd0);

        rtype(6'h21, 5'd1, 5'd0, 5'd4, 32'd7, 32'd0);
        step("addu_r4b");
        clear_inputs();
        i_ALU_src = 1; i_imm = 32'h10; i_rt = 5'd4; i_MEM_write = 1;
        i_MEM_byte_half_word = 2'b11;
        step("sw_fwd");
        chk("sw_fwd.const", o_data_to_write_in_MEM, 32'd7);

        clear_inputs();
        i_ALU_src = 1; i_rs_data = 32'h100; i_rt = 5'd6; i_MEM_read = 1;
        i_WB_write = 1; i_WB_mem_to_reg = 1; i_MEM_byte_half_word = 2'b11;
        step("lw_r6");
        rtype(6'h21, 5'd6, 5'd0, 5'd7, 32'h11, 32'd0);
        i_fwd_WB_write = 1; i_fwd_WB_reg = 5'd6; i_fwd_WB_data = 32'h22;
        step("load_no_fwd");
        chk("load_no_fwd.const", o_ALU_result, 32'h22);

        rtype(6'h21, 5'd1, 5'd0, 5'd0, 32'h55, 32'd0);
        step("write_r0");
        rtype(6'h21, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
        step("r0_no_fwd");
        chk("r0_no_fwd.const", o_ALU_result, 32'd0);

        rtype(6'h03, 5'd0, 5'd7, 5'd10, 32'd0, 32'h8000_0000);
        i_shamt = 5'd4;
        step("sra");
        chk("sra.const", o_ALU_result, 32'hF800_0000);
        rtype(6'h2A, 5'd1, 5'd2, 5'd11, 32'hFFFF_FFFF, 32'd1);
        step("slt");
        chk("slt.const", o_ALU_result, 32'd1);
        rtype(6'h2B, 5'd1, 5'd2, 5'd12, 32'hFFFF_FFFF, 32'd1);
        step("sltu");
        chk("sltu.const", o_ALU_result, 32'd0);

        clear_inputs();
        i_ALU_op = 3'b110; i_ALU_src = 1; i_imm = 32'h1234; i_rt = 5'd8; i_WB_write = 1;
        step("lui");
        chk("lui.const", o_ALU_result, 32'h1234_0000);

        clear_inputs();
        i_link = 1; i_return_addr = 32'h40; i_WB_write = 1; i_rt = 5'd3;
        step("jal");
        chk("jal.const_result", o_ALU_result, 32'h40);
        chk("jal.const_wreg", 32'(o_write_reg), 32'd31);

        for (int k = 0; k < 3; k++) begin
            rtype(6'h25, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(1, 31)), $urandom, $urandom);
            i_enable = 0;
            i_flush = 1'($urandom_range(0, 1));
            step("hold");
            chk("hold.const", o_ALU_result, 32'h40);
        end

        rtype(6'h21, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
        i_flush = 1; i_MEM_write = 1;
        step("flush");
        chk("flush.const", {o_ALU_result[15:0], 11'(o_write_reg), o_WB_write, o_MEM_write,
                            o_MEM_read, o_MEM_byte_half_word}, 32'd0);

        rtype(6'h21, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2);
        step("pre_reset");
        #2 i_reset = 1;
        #1;
        model_clear();
        compare_all("async_reset");
        chk("async_reset.const", o_ALU_result, 32'd0);
        #1 i_reset = 0;
        step("post_reset");

        for (int n = 0; n < 300; n++) begin
            logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h21,
                                     6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
            i_enable = ($urandom_range(0, 9) != 0);
            i_flush  = ($urandom_range(0, 9) == 0);
            i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
            i_return_addr = $urandom; i_fwd_WB_data = $urandom;
            i_rs = 5'($urandom_range(0, 5)); i_rt = 5'($urandom_range(0, 5));
            i_rd = 5'($urandom_range(0, 5)); i_fwd_WB_reg = 5'($urandom_range(0, 5));
            i_shamt = 5'($urandom); i_funct = fns[$urandom_range(0, 15)];
            i_ALU_op = 3'($urandom); i_ALU_src = 1'($urandom); i_reg_dst = 1'($urandom);
            i_link = ($urandom_range(0, 7) == 0);
            i_WB_write = 1'($urandom); i_WB_mem_to_reg = 1'($urandom);
            i_MEM_read = ($urandom_range(0, 3) == 0); i_MEM_write = 1'($urandom);
            i_MEM_unsigned = 1'($urandom); i_MEM_byte_half_word = 2'($urandom);
            i_fwd_WB_write = 1'($urandom);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
